// File: rtl/boolean_sweep_ctrl_pkg.sv
// Shared definitions for the Boolean sweep controller: 2-bit state encodings
// and the default settle time and expected truth table (3-input majority).
package boolean_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } sweep_state_e;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;
  localparam logic [7:0]  DEFAULT_EXPECTED      = 8'hE8;
  localparam int unsigned TIMER_W               = 4;
  localparam logic [2:0]  LAST_VEC              = 3'd7;

endpackage

// File: rtl/settle_timer.sv
// 4-bit down-counter: load sets the count, enable decrements toward zero,
// expired is high while the count is zero.
module settle_timer
  import boolean_sweep_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               enable,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Steps an external 3-input function unit through all 8 input vectors,
// samples F after a settle time and checks it against an expected truth table.
module boolean_sweep_ctrl
  import boolean_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter logic [7:0]  EXPECTED      = DEFAULT_EXPECTED
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         f_in,
  output logic         a_out,
  output logic         b_out,
  output logic         c_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   fail_count,
  output logic [2:0]   first_fail_vec,
  output logic [7:0]   captured,
  output sweep_state_e state_dbg
);

  // Loaded on SETTLE entry so the timer hits zero in the last SETTLE cycle.
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  sweep_state_e state, state_d;
  logic [2:0]   idx, idx_d;
  logic         busy_d, done_d, pass_d;
  logic [3:0]   fail_count_d;
  logic [2:0]   first_fail_d;
  logic [7:0]   captured_d;
  logic         timer_load, timer_expired, mismatch;

  settle_timer u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TIMER_LOAD),
    .enable     (state == ST_SETTLE),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      captured       <= '0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      fail_count     <= fail_count_d;
      first_fail_vec <= first_fail_d;
      captured       <= captured_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    fail_count_d = fail_count;
    first_fail_d = first_fail_vec;
    captured_d   = captured;
    timer_load   = 1'b0;
    mismatch     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SETTLE;
          idx_d        = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_count_d = '0;
          first_fail_d = '0;
          captured_d   = '0;
          timer_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        mismatch        = (f_in != EXPECTED[idx]);
        captured_d[idx] = f_in;
        if (mismatch) begin
          fail_count_d = fail_count + 4'd1;
          if (fail_count == '0) first_fail_d = idx;
        end
        // pass must include the last vector, so it is taken from the next count.
        if (idx == LAST_VEC) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == '0);
        end else begin
          state_d    = ST_SETTLE;
          idx_d      = idx + 3'd1;
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_out     = idx[2];
  assign b_out     = idx[1];
  assign c_out     = idx[0];
  assign state_dbg = state;

endmodule
